// File: rtl/key_event_encoder.sv
// Key-matrix event encoder: whole-vector debounce, per-key edge scan, and an
// ordered FWFT event FIFO with sticky overflow toward the note/sound logic.
module key_event_encoder #(
  parameter int NUM_KEYS         = 32,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_KEYS-1:0]         key_pressed,
  input  logic                        sample_valid,
  input  logic                        event_ready,
  output logic                        event_valid,
  output logic [$clog2(NUM_KEYS)-1:0] event_key,
  output logic                        event_press,
  output logic [NUM_KEYS-1:0]         key_state,
  output logic                        overflow,
  input  logic                        clear_overflow
);

  localparam int IDX_W  = $clog2(NUM_KEYS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t              state_q, state_d;
  logic [NUM_KEYS-1:0] key_state_q, key_state_d;
  logic [NUM_KEYS-1:0] cand_q, cand_d;
  logic [NUM_KEYS-1:0] diff_q, diff_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                overflow_q, overflow_d;

  logic [IDX_W:0]      fifo_mem [FIFO_DEPTH];
  logic                push, push_ok, pop, full;
  logic [IDX_W:0]      push_data;

  // Debounce runs regardless of FSM state; count saturates at the threshold.
  always_comb begin
    cand_d  = cand_q;
    count_d = count_q;
    if (sample_valid) begin
      if (key_pressed == cand_q) begin
        if (count_q != CNT_W'(DEBOUNCE_SAMPLES)) begin
          count_d = count_q + CNT_W'(1);
        end
      end else begin
        cand_d  = key_pressed;
        count_d = CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    key_state_d = key_state_q;
    diff_d      = diff_q;
    idx_d       = idx_q;
    push        = 1'b0;
    push_data   = '0;
    case (state_q)
      IDLE: begin
        if (count_q == CNT_W'(DEBOUNCE_SAMPLES) && cand_q != key_state_q) begin
          key_state_d = cand_q;
          diff_d      = cand_q ^ key_state_q;
          idx_d       = '0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        // key_state already holds the new vector, so its bit is the press flag.
        push      = diff_q[idx_q];
        push_data = {idx_q, key_state_q[idx_q]};
        idx_d     = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_KEYS - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    full    = (fcnt_q == FCNT_W'(FIFO_DEPTH));
    pop     = (fcnt_q != '0) && event_ready;
    push_ok = push && (!full || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    fcnt_d   = fcnt_q;
    case ({push_ok, pop})
      2'b10:   fcnt_d = fcnt_q + FCNT_W'(1);
      2'b01:   fcnt_d = fcnt_q - FCNT_W'(1);
      default: fcnt_d = fcnt_q;
    endcase
    // A drop in the same cycle as a clear request keeps the flag set.
    overflow_d = overflow_q;
    if (push && !push_ok) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      key_state_q <= '0;
      cand_q      <= '0;
      diff_q      <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fcnt_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_state_q <= key_state_d;
      cand_q      <= cand_d;
      diff_q      <= diff_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fcnt_q      <= fcnt_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage has no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= push_data;
    end
  end

  assign event_valid              = (fcnt_q != '0);
  assign {event_key, event_press} = fifo_mem[rd_ptr_q];
  assign key_state                = key_state_q;
  assign overflow                 = overflow_q;

endmodule
